uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised next-generation UART transmitter: configurable data width, runtime parity and stop-bit selection, internal baud prescaler, and a one-deep holding register so frames go out back-to-back with no idle gap. Sits between the system register/FIFO side and the TX pin, replacing the fixed 8-bit, one-bit-per-clock transmitter. Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop(1).

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal 5..9
PRESCALE_W, 6, width of PRESCALE port

Ports:
CLK  input  1  single clock
RST  input  1  reset, synchronous, active-high
P_DATA  input  DATA_WIDTH  parallel payload
DATA_VALID  input  1  payload offer; transfer when DATA_VALID && DATA_READY
DATA_READY  output  1  holding register empty
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  1 = two stop bits
PRESCALE  input  PRESCALE_W  clocks per bit; 0 treated as 1
TX_OUT  output  1  serial line, idle high
Busy  output  1  frame in progress

Behaviour:
- Reset: TX_OUT=1, Busy=0, DATA_READY=1, holding register empty, state IDLE, counters 0. Synchronous; reset mid-frame aborts; TX_OUT is 1 from the first cycle after the RST edge; any held word is discarded.
- Holding register: captures P_DATA on handshake; DATA_READY=0 while full. Full clears the cycle the shifter loads it. Handshake while shifting is legal (double-buffering).
- Config (PAR_EN, PAR_TYP, STOP2, PRESCALE) and parity latch with the word at load; changes mid-frame have no effect on that frame.
- Parity: XOR of all DATA_WIDTH bits; even → bit = XOR; odd → bit = ~XOR.
- Bit timer: counts 0..max(PRESCALE,1)-1; each bit held exactly max(PRESCALE,1) clocks.
- FSM: IDLE → START when holding full (load in same cycle; START drives 0 from the next cycle). START → DATA after one bit time. DATA shifts out bits 0..DATA_WIDTH-1. DATA → PARITY if PAR_EN else STOP. PARITY → STOP. STOP lasts 1 or 2 bit times; at end, holding full → START directly (zero idle clocks), else IDLE.
- Latency: handshake in IDLE → TX_OUT falls 2 cycles later (capture, load).
- Busy=1 in START/DATA/PARITY/STOP; 0 in IDLE. TX_OUT registered, glitch-free.
- Frame length = (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × max(PRESCALE,1) clocks.
- Simultaneous handshake and load in same cycle: load takes current held word, new word captured; DATA_READY stays 0.

Optional Feature:
UART_TX_BREAK_EN: adds input SEND_BREAK. When asserted in IDLE, FSM enters BREAK, TX_OUT=0 and Busy=1 while asserted; on deassert, one full stop-bit time of 1 then IDLE. SEND_BREAK ignored mid-frame (sampled only in IDLE); held word waits. Without macro: no port, no BREAK state.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK), parity-type constants PAR_EVEN=0/PAR_ODD=1, DATA_WIDTH legal-range constants.
- One sub-module: uart_baud_tick (prescale counter, emits bit-end tick, restarts on load).

Test Plan:
- Reset: RST=1 2 cycles → TX_OUT=1, Busy=0, DATA_READY=1.
- DATA_WIDTH=8, PRESCALE=4, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 → line 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 clocks; Busy 44 clocks.
- Two words 0x55, 0x0F offered consecutively, PRESCALE=1, STOP2=1 → second start bit immediately follows second stop bit, DATA_READY low until second load.
- PRESCALE=0, PAR_EN=0, odd-irrelevant, P_DATA=0xFF → 10-clock frame, 1-clock bits.
- PAR_TYP=1, P_DATA=0x00 → parity bit 1; changing PAR_TYP mid-frame leaves bit 1.
- RST mid DATA state with held word → TX_OUT=1 next cycle, DATA_READY=1, no further frame.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the configurable UART transmitter
//   FSM state encodings (IDLE, START, DATA, PARITY, STOP, BREAK)
//   parity-type values PAR_EVEN / PAR_ODD
//   legal DATA_WIDTH range DW_MIN..DW_MAX
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DW_MIN = 5;
  localparam int DW_MAX = 9;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-time prescale counter with bit-end tick
//   clk      : clock
//   rst      : synchronous active-high reset
//   restart  : force counter to 0 (frame load / break exit)
//   en       : count enable (transmitter not idle)
//   prescale : clocks per bit, 0 treated as 1
//   tick     : high on the last clock of each bit time
module uart_baud_tick #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] last;

  // A prescale of 0 behaves like 1: every clock ends a bit.
  assign last = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);
  assign tick = en && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with one-deep holding register
//   CLK, RST    : clock, synchronous active-high reset
//   P_DATA      : payload, handshake DATA_VALID && DATA_READY
//   DATA_READY  : holding register empty
//   PAR_EN/PAR_TYP/STOP2/PRESCALE : frame config, latched at frame load
//   TX_OUT      : registered serial line, idle high
//   Busy        : frame (or break) in progress
//   SEND_BREAK  : present only when UART_TX_BREAK_EN is defined
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] PRESCALE,
`ifdef UART_TX_BREAK_EN
  input  logic                  SEND_BREAK,
`endif
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tx_q, tx_d;

  logic hs;
  logic load;
  logic restart;
  logic tick;

  assign hs         = DATA_VALID && !hold_full_q;
  assign DATA_READY = !hold_full_q;
  assign TX_OUT     = tx_q;
  assign Busy       = (state_q != ST_IDLE);

  uart_baud_tick #(
    .PRESCALE_W(PRESCALE_W)
  ) u_baud_tick (
    .clk     (CLK),
    .rst     (RST),
    .restart (restart),
    .en      (state_q != ST_IDLE),
    .prescale(pre_q),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    stop_cnt_d  = stop_cnt_q;
    pre_d       = pre_q;
    tx_d        = tx_q;
    load        = 1'b0;
    restart     = 1'b0;

    if (hs) begin
      hold_d = P_DATA;
    end

    // tx_d always reflects the line value of the state being entered, so
    // TX_OUT changes on the same edge as the state register.
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (SEND_BREAK) begin
          state_d = ST_BREAK;
          tx_d    = 1'b0;
        end else
`endif
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            stop_cnt_d = 1'b0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else if (hold_full_q) begin
            // Back-to-back: next start bit follows the last stop bit directly.
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        tx_d = 1'b0;
        if (!SEND_BREAK) begin
          // Release into a single stop-bit time at the current prescale.
          state_d    = ST_STOP;
          stop2_d    = 1'b0;
          stop_cnt_d = 1'b0;
          pre_d      = PRESCALE;
          restart    = 1'b1;
          tx_d       = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      state_d    = ST_START;
      tx_d       = 1'b0;
      shift_d    = hold_q;
      par_en_d   = PAR_EN;
      par_bit_d  = (PAR_TYP == PAR_ODD) ? ~(^hold_q) : (^hold_q);
      stop2_d    = STOP2;
      stop_cnt_d = 1'b0;
      pre_d      = PRESCALE;
      restart    = 1'b1;
    end

    hold_full_d = (hold_full_q && !load) || hs;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_cnt_q  <= 1'b0;
      pre_q       <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      stop2_q     <= stop2_d;
      stop_cnt_q  <= stop_cnt_d;
      pre_q       <= pre_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       DATA_READY;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [5:0] PRESCALE = 6'd1;
  logic       TX_OUT;
  logic       Busy;
`ifdef UART_TX_BREAK_EN
  logic       SEND_BREAK = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  uart_tx_cfg #(
    .DATA_WIDTH(8),
    .PRESCALE_W(6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .STOP2     (STOP2),
    .PRESCALE  (PRESCALE),
`ifdef UART_TX_BREAK_EN
    .SEND_BREAK(SEND_BREAK),
`endif
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic send_word(input logic [7:0] d);
    int waited = 0;
    while (!DATA_READY && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    check("send_ready", DATA_READY, 1);
    P_DATA     = d;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  // bits[0] is the first bit on the line; each bit lasts p clocks.
  task automatic check_line(input string tag, input logic [15:0] bits,
                            input int nbits, input int p);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < p; c++) begin
        check($sformatf("%s_tx_b%0d_c%0d", tag, b, c), TX_OUT, bits[b]);
        check($sformatf("%s_busy_b%0d", tag, b), Busy, 1);
        @(negedge CLK);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, TX_OUT, 1);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_ready"}, DATA_READY, 1);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge CLK);
    check_idle("reset");
    RST = 1'b0;
    @(negedge CLK);

    // 0xA5, prescale 4, even parity: 0,1,0,1,0,0,1,0,1,0,1
    PRESCALE = 6'd4; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    send_word(8'hA5);
    check("a5_lat_tx", TX_OUT, 1);
    check("a5_lat_busy", Busy, 0);
    check("a5_lat_ready", DATA_READY, 0);
    @(negedge CLK);
    check_line("a5", 16'b101_0100_1010, 11, 4);
    check_idle("a5_end");

    // Back-to-back 0x55 then 0x0F, prescale 1, two stop bits
    PRESCALE = 6'd1; PAR_EN = 1'b0; STOP2 = 1'b1;
    send_word(8'h55);
    @(negedge CLK);
    fork
      check_line("w55", 16'b110_1010_1010, 11, 1);
      begin
        check("w0f_offer_ready", DATA_READY, 1);
        P_DATA     = 8'h0F;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        for (int i = 0; i < 10; i++) begin
          check($sformatf("w0f_held_ready_%0d", i), DATA_READY, 0);
          @(negedge CLK);
        end
      end
    join
    check("w0f_loaded_ready", DATA_READY, 1);
    check_line("w0f", 16'b110_0001_1110, 11, 1);
    check_idle("w0f_end");

    // Prescale 0 acts as 1, no parity: 10-clock frame
    PRESCALE = 6'd0; PAR_EN = 1'b0; STOP2 = 1'b0; PAR_TYP = 1'b1;
    send_word(8'hFF);
    @(negedge CLK);
    check_line("ff", 16'b11_1111_1110, 10, 1);
    check_idle("ff_end");

    // Odd parity on 0x00, config changed mid-frame must not matter
    PRESCALE = 6'd2; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b0;
    send_word(8'h00);
    @(negedge CLK);
    fork
      check_line("p00", 16'b110_0000_0000, 11, 2);
      begin
        repeat (3) @(negedge CLK);
        PAR_TYP  = 1'b0;
        PRESCALE = 6'd5;
        PAR_EN   = 1'b0;
        STOP2    = 1'b1;
      end
    join
    check_idle("p00_end");

    // Reset in the middle of DATA with a word held
    PRESCALE = 6'd4; PAR_EN = 1'b0; STOP2 = 1'b0;
    send_word(8'h3C);
    @(negedge CLK);
    P_DATA     = 8'hC3;
    DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (11) @(negedge CLK);
    check("abort_pre_tx", TX_OUT, 1);
    check("abort_pre_busy", Busy, 1);
    check("abort_pre_ready", DATA_READY, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_idle("abort_post");
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check($sformatf("abort_quiet_tx_%0d", i), TX_OUT, 1);
      check($sformatf("abort_quiet_busy_%0d", i), Busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
